// File: rtl/matmul_controller.sv
// matmul_controller
//   Streams two 3x3 byte matrices A and B (row-major, A first) into external
//   memories, then computes C = A x B, one result element at a time, and
//   hands the elements out row-major over a valid/ready port.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   start             begin a new job (honoured only in IDLE)
//   in_valid/in_data  input byte stream; in_ready high while loading
//   mem_addr          element address 0..8 shared by both memories
//   mem_wdata         write data to both memories
//   a_we, b_we        write enables for the A / B memories
//   mem_re            read enable: memories capture their 72-bit images
//   a_data, b_data    memory images, element n at bits [8n+7:8n]
//   out_valid/out_data/out_ready  result handshake; out_data is C[i][j]
//   busy              high in every state except IDLE
//   done              one-cycle pulse after the last result is accepted
module matmul_controller #(
  parameter int ACC_W = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [3:0]       mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             a_we,
  output logic             b_we,
  output logic             mem_re,
  input  logic [71:0]      a_data,
  input  logic [71:0]      b_data,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_FETCH,
    ST_WAIT,
    ST_COMPUTE,
    ST_OUTPUT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [3:0]       n;
  logic [1:0]       i;
  logic [1:0]       j;
  logic [1:0]       k;
  logic [ACC_W-1:0] acc;
  logic             done_r;

  logic             loading;
  logic             accept;
  logic             last_elem;
  logic [3:0]       a_idx;
  logic [3:0]       b_idx;
  logic [7:0]       a_elem;
  logic [7:0]       b_elem;
  logic [15:0]      prod;

  // Operand selection: A[3i+k] and B[3k+j]; product forced to 0 outside
  // COMPUTE so the memory images are only consumed there.
  always_comb begin
    a_idx  = {1'b0, i, 1'b0} + {2'b00, i} + {2'b00, k};
    b_idx  = {1'b0, k, 1'b0} + {2'b00, k} + {2'b00, j};
    a_elem = '0;
    b_elem = '0;
    if (state == ST_COMPUTE) begin
      a_elem = a_data[{a_idx, 3'b000} +: 8];
      b_elem = b_data[{b_idx, 3'b000} +: 8];
    end
    prod = a_elem * b_elem;
  end

  always_comb begin
    loading   = (state == ST_LOAD_A) || (state == ST_LOAD_B);
    accept    = in_valid && loading;
    last_elem = (i == 2'd2) && (j == 2'd2);

    in_ready  = loading;
    a_we      = in_valid && (state == ST_LOAD_A);
    b_we      = in_valid && (state == ST_LOAD_B);
    mem_addr  = n;
    mem_wdata = loading ? in_data : '0;
    mem_re    = (state == ST_FETCH);
    out_valid = (state == ST_OUTPUT);
    out_data  = out_valid ? acc : '0;
    busy      = (state != ST_IDLE);
    done      = done_r;

    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = ST_LOAD_A;
      ST_LOAD_A:  if (accept && n == 4'd8) state_next = ST_LOAD_B;
      ST_LOAD_B:  if (accept && n == 4'd8) state_next = ST_FETCH;
      ST_FETCH:   state_next = ST_WAIT;
      ST_WAIT:    state_next = ST_COMPUTE;
      ST_COMPUTE: if (k == 2'd2) state_next = ST_OUTPUT;
      ST_OUTPUT:  if (out_ready) state_next = last_elem ? ST_IDLE : ST_COMPUTE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      n      <= '0;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      acc    <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_next;
      done_r <= (state == ST_OUTPUT) && out_ready && last_elem;
      case (state)
        ST_IDLE: begin
          if (start) n <= '0;
        end
        ST_LOAD_A, ST_LOAD_B: begin
          if (accept) n <= (n == 4'd8) ? 4'd0 : n + 4'd1;
        end
        ST_WAIT: begin
          // Entry into the first COMPUTE: result (0,0), accumulator cleared.
          i   <= '0;
          j   <= '0;
          k   <= '0;
          acc <= '0;
        end
        ST_COMPUTE: begin
          acc <= acc + ACC_W'(prod);
          k   <= (k == 2'd2) ? 2'd0 : k + 2'd1;
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            acc <= '0;
            k   <= '0;
            if (j == 2'd2) begin
              j <= '0;
              i <= last_elem ? 2'd0 : i + 2'd1;
            end else begin
              j <= j + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
